// File: rtl/da_fir_engine.sv
// Distributed-arithmetic FIR engine: keeps the tap delay line, walks it
// bit-serially LSB first, addresses the coefficient ROM with one bit-slice per
// cycle and shift-accumulates the returned partial sums into the output.
module da_fir_engine #(
  parameter int unsigned TAPS      = 7,
  parameter int unsigned DWIDTH    = 12,
  parameter int unsigned OPSIZE    = 12,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned OUT_W     = OPSIZE + DWIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [DWIDTH-1:0]    i_sample,
  output logic                 o_ready,
  output logic                 o_rom_oe,
  output logic [ADDR_SIZE-1:0] o_rom_addr,
  input  logic [OPSIZE-1:0]    i_rom_data,
  output logic                 o_valid,
  output logic [OUT_W-1:0]     o_data,
  input  logic                 i_ready
);

  localparam int unsigned CNT_W = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                         state_q, state_d;
  logic [TAPS-1:0][DWIDTH-1:0]    x_q, x_d;
  logic [OUT_W-1:0]               acc_q, acc_d;
  logic [CNT_W-1:0]               b_q, b_d;
  logic [OUT_W-1:0]               data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           ready_q, ready_d;
  logic                           oe_q, oe_d;
  logic [ADDR_SIZE-1:0]           addr_q, addr_d;
  logic [OUT_W-1:0]               term_c;

  // Sign-extended ROM word weighted by the current bit position.
  always_comb begin
    term_c = {{(OUT_W-OPSIZE){i_rom_data[OPSIZE-1]}}, i_rom_data} << b_q;
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    b_d     = b_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ready_d = 1'b0;
    oe_d    = 1'b0;
    addr_d  = '0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          for (int k = 1; k < int'(TAPS); k++) x_d[k] = x_q[k-1];
          x_d[0]  = i_sample;
          acc_d   = '0;
          b_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (b_q == CNT_W'(DWIDTH - 1)) begin
          // MSB carries negative weight in two's complement.
          acc_d   = acc_q - term_c;
          data_d  = acc_d;
          state_d = DONE;
        end else begin
          acc_d = acc_q + term_c;
          b_d   = b_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // ROM address/enable are prepared one cycle ahead for the bit used next.
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
    oe_d    = (state_d == CALC);
    if (state_d == CALC) begin
      for (int k = 0; k < int'(TAPS); k++) addr_d[k] = x_d[k][b_d];
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      oe_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_rom_oe   = oe_q;
  assign o_rom_addr = addr_q;

endmodule

// File: tb/tb_da_fir_engine.sv
// Testbench for da_fir_engine: directed and random samples against a plain
// convolution model of the FIR with coefficients h = {1, 2, 3}.
module tb_da_fir_engine;

  localparam int unsigned TAPS      = 3;
  localparam int unsigned DWIDTH    = 4;
  localparam int unsigned OPSIZE    = 8;
  localparam int unsigned ADDR_SIZE = 3;
  localparam int unsigned OUT_W     = 12;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_valid;
  logic [DWIDTH-1:0]    i_sample;
  logic                 o_ready;
  logic                 o_rom_oe;
  logic [ADDR_SIZE-1:0] o_rom_addr;
  logic [OPSIZE-1:0]    i_rom_data;
  logic                 o_valid;
  logic [OUT_W-1:0]     o_data;
  logic                 i_ready;

  int h [TAPS] = '{1, 2, 3};
  int hist [TAPS];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = -1;
  bit stream_mode = 0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Coefficient ROM: sum of h[k] over the set address bits.
  function automatic logic [OPSIZE-1:0] rom_word(input logic [ADDR_SIZE-1:0] a);
    int s = 0;
    for (int k = 0; k < int'(TAPS); k++) if (a[k]) s += h[k];
    return OPSIZE'(s);
  endfunction

  assign i_rom_data = rom_word(o_rom_addr);

  da_fir_engine #(
    .TAPS(TAPS), .DWIDTH(DWIDTH), .OPSIZE(OPSIZE),
    .ADDR_SIZE(ADDR_SIZE), .OUT_W(OUT_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sample(i_sample),
    .o_ready(o_ready), .o_rom_oe(o_rom_oe), .o_rom_addr(o_rom_addr),
    .i_rom_data(i_rom_data), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_out();
    int s = 0;
    for (int k = 0; k < int'(TAPS); k++) s += h[k] * hist[k];
    return OUT_W'(s);
  endfunction

  function automatic logic [31:0] model_addr(input int b);
    logic [31:0] a = '0;
    for (int k = 0; k < int'(TAPS); k++) a[k] = ((hist[k] >>> b) & 1) != 0;
    return a;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_data"}, 32'(o_data), 0);
    check({tag, "_oe"}, 32'(o_rom_oe), 0);
    check({tag, "_addr"}, 32'(o_rom_addr), 0);
    check({tag, "_ready"}, 32'(o_ready), 1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    for (int k = 0; k < int'(TAPS); k++) hist[k] = 0;
    last_acc = -1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("ready_wait", 32'(o_ready), 1);
  endtask

  // One sample through the engine; bp > 0 holds i_ready low for bp cycles.
  task automatic run_sample(input logic [DWIDTH-1:0] s, input int bp);
    logic [OUT_W-1:0] exp;
    wait_ready();
    i_valid  = 1'b1;
    i_sample = s;
    if (bp > 0) i_ready = 1'b0;
    @(posedge i_clk); #1;
    if (!stream_mode) i_valid = 1'b0;
    if (stream_mode && last_acc >= 0) check("spacing", 32'(cyc - last_acc), DWIDTH + 2);
    last_acc = cyc;
    for (int k = int'(TAPS) - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'($signed(s));
    exp = model_out();
    // Bit-serial phase: one ROM access per input bit, no valid yet.
    for (int b = 0; b < int'(DWIDTH); b++) begin
      check("calc_oe", 32'(o_rom_oe), 1);
      check("calc_addr", 32'(o_rom_addr), model_addr(b));
      check("calc_ready", 32'(o_ready), 0);
      check("calc_valid", 32'(o_valid), 0);
      @(posedge i_clk); #1;
    end
    check("latency_valid", 32'(o_valid), 1);
    check("out_data", 32'(o_data), 32'(exp));
    check("done_oe", 32'(o_rom_oe), 0);
    for (int i = 0; i < bp; i++) begin
      if (i == 2) begin
        i_valid  = 1'b1;
        i_sample = ~s;
      end
      @(posedge i_clk); #1;
      i_valid = stream_mode;
      check("bp_valid", 32'(o_valid), 1);
      check("bp_data", 32'(o_data), 32'(exp));
      check("bp_ready", 32'(o_ready), 0);
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    check("post_valid", 32'(o_valid), 0);
    check("post_ready", 32'(o_ready), 1);
    check("post_hold", 32'(o_data), 32'(exp));
  endtask

  initial begin
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_sample = '0;
    i_ready  = 1'b1;
    #2;
    do_reset();

    // Impulse response walks out the coefficients.
    run_sample(4'd1, 0);
    run_sample(4'd0, 0);
    run_sample(4'd0, 0);
    run_sample(4'd0, 0);

    // Address trace for 0101 and a negative sample.
    do_reset();
    run_sample(4'd5, 0);
    do_reset();
    run_sample(4'hF, 0);

    // Step input.
    do_reset();
    run_sample(4'd2, 0);
    run_sample(4'd2, 0);
    run_sample(4'd2, 0);

    // Back-pressure with an ignored sample pulse, then confirm history.
    run_sample(4'd3, 6);
    run_sample(4'd1, 0);

    // Reset in the second CALC cycle aborts the sample.
    wait_ready();
    i_valid  = 1'b1;
    i_sample = 4'd7;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    for (int k = 0; k < int'(TAPS); k++) hist[k] = 0;
    for (int i = 0; i < int'(DWIDTH) + 2; i++) begin
      @(posedge i_clk); #1;
      check("abort_novalid", 32'(o_valid), 0);
    end
    run_sample(4'd1, 0);
    run_sample(4'd0, 0);
    run_sample(4'd0, 0);

    // Full-rate random stream with i_valid held high.
    do_reset();
    stream_mode = 1;
    for (int n = 0; n < 20; n++) run_sample(DWIDTH'($urandom), 0);
    stream_mode = 0;
    i_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
